// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM and owner
// encodings, the default starvation limit and the arbitration rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Data side wins a collision unless fetch has been starved to the limit.
  function automatic owner_e arb_pick(input logic i_req, input logic d_req,
                                      input logic starved);
    if (i_req && (!d_req || starved)) return OWN_I;
    return OWN_D;
  endfunction

  // Counter width able to hold 0..limit (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of data grants taken while fetch was waiting; sat_out
// tells the arbiter that fetch must win the next collision.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat_out
);

  localparam int              CW      = cnt_width(LIMIT);
  localparam logic [CW-1:0]   LIMIT_V = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d is given its hold value before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sat_out = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory. One
// transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic   starved;
  logic   grant_any;
  logic   cnt_inc;
  logic   cnt_clr;
  owner_e pick;

  // Requests are only looked at in IDLE; a grant there starts a transaction.
  assign grant_any = (state_q == ST_IDLE) && (i_req || d_req);
  assign pick      = arb_pick(i_req, d_req, starved);
  assign cnt_clr   = grant_any && (pick == OWN_I);
  assign cnt_inc   = grant_any && (pick == OWN_D) && i_req;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .sat_out (starved)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_ISSUE;
          owner_d = pick;
          if (pick == OWN_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            addr_d  = i_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end

      // Completion may arrive as early as the issue cycle itself.
      ST_ISSUE, ST_WAIT: begin
        if (state_q == ST_ISSUE) state_d = ST_WAIT;
        if (mem_valid) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) d_rdata_d = mem_rdata;
          else                  i_rdata_d = mem_rdata;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_wr    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_done  = (state_q == ST_RESP) && (owner_q == OWN_I);
  assign d_done  = (state_q == ST_RESP) && (owner_q == OWN_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  // Stalls are purely combinational so they stay meaningful through reset.
  assign i_stall = i_req && !i_done;
  assign d_stall = d_req && !d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_rdata, d_rdata;
  logic        i_done, d_done, i_stall, d_stall;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural memory: written locations remember data, others read addr^5A5A.
  logic [15:0] mem_model [bit [15:0]];

  function automatic logic [15:0] read_mem(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'h5A5A;
  endfunction

  int          lat_cfg = 1;   // 0 selects a random latency 1..4 per access
  bit          spur    = 1'b0;
  int          cd      = 0;
  logic [15:0] resp    = '0;

  // Memory responder: mem_valid lands L cycles after the cycle mem_en is seen.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = spur;
      if (spur) mem_rdata = 16'hDEAD;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_valid = 1'b1;
          mem_rdata = resp;
        end
      end
      @(negedge clk);
      if (mem_en === 1'b1) begin
        cd = (lat_cfg > 0) ? lat_cfg : $urandom_range(1, 4);
        if (mem_wr === 1'b1) begin
          mem_model[mem_addr] = mem_wdata;
          resp = 16'h0000;
        end else begin
          resp = read_mem(mem_addr);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    tick(); tick(); rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    int          lat;
    logic        exp_d;      // 1: data port owns the transaction
    logic [15:0] exp_addr;
    logic        exp_wr;
    logic [15:0] exp_data;   // read data at done (reads only)
  } vec_t;

  function automatic vec_t mk(input string n, input logic ir, input logic dr, input logic we,
                              input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                              input int l, input logic ed, input logic [15:0] ea,
                              input logic ew, input logic [15:0] edata);
    vec_t v;
    v.name = n; v.i_req = ir; v.d_req = dr; v.d_we = we;
    v.i_addr = ia; v.d_addr = da; v.d_wdata = wd; v.lat = l;
    v.exp_d = ed; v.exp_addr = ea; v.exp_wr = ew; v.exp_data = edata;
    return v;
  endfunction

  // One transaction from IDLE: issue at cycle 1, done at cycle 2+L.
  task automatic run_vec(input vec_t v);
    int          en_at, done_at, dl;
    logic        got_d, got_wr;
    logic [15:0] got_data, got_addr, got_wd;
    en_at = -1; done_at = -1; got_d = 1'b0; got_wr = 1'b0;
    got_data = '0; got_addr = '0; got_wd = '0;
    dl = 2 + v.lat;
    tick();
    lat_cfg = v.lat;
    i_req = v.i_req; d_req = v.d_req; d_we = v.d_we;
    i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k <= dl) begin
        check({v.name, "/i_stall"}, i_stall, v.i_req && !(k == dl && !v.exp_d));
        check({v.name, "/d_stall"}, d_stall, v.d_req && !(k == dl && v.exp_d));
      end
      if (mem_en === 1'b1 && en_at < 0) begin
        en_at = k; got_wr = mem_wr; got_addr = mem_addr; got_wd = mem_wdata;
      end
      if ((i_done === 1'b1 || d_done === 1'b1) && done_at < 0) begin
        done_at  = k;
        got_d    = d_done;
        got_data = d_done ? d_rdata : i_rdata;
        break;
      end
      tick();
    end
    check({v.name, "/en_cycle"}, en_at, 1);
    check({v.name, "/mem_wr"}, got_wr, v.exp_wr);
    check({v.name, "/mem_addr"}, got_addr, v.exp_addr);
    if (v.exp_wr) check({v.name, "/mem_wdata"}, got_wd, v.d_wdata);
    check({v.name, "/done_cycle"}, done_at, dl);
    check({v.name, "/owner"}, got_d, v.exp_d);
    if (!v.exp_wr) check({v.name, "/rdata"}, got_data, v.exp_data);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check({v.name, "/done_width"}, i_done || d_done, 1'b0);
  endtask

  // Transaction-level reference state for the random phase.
  int          m_cyc, m_next_arb, m_issue, m_done, m_starve;
  bit          m_busy, m_own_d, m_we;
  logic [15:0] m_addr, m_wdata, m_i_rd, m_d_rd;

  initial begin : main
    vec_t vecs[6];
    int   en_cyc[$];
    bit   en_own_d[$];
    int   d_done_at, i_done_at;
    logic [15:0] i_data_at_done;

    rst = 1'b1; i_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_model[16'h0010] = 16'hA5A5;

    // Reset state, with i_req high to show the stall path stays live.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/mem_en", mem_en, 1'b0);
    check("rst/mem_wr", mem_wr, 1'b0);
    check("rst/mem_addr", mem_addr, 16'h0);
    check("rst/mem_wdata", mem_wdata, 16'h0);
    check("rst/i_done", i_done, 1'b0);
    check("rst/d_done", d_done, 1'b0);
    check("rst/i_rdata", i_rdata, 16'h0);
    check("rst/d_rdata", d_rdata, 16'h0);
    check("rst/i_stall", i_stall, 1'b1);
    check("rst/d_stall", d_stall, 1'b0);
    tick(); rst = 1'b0; i_req = 1'b0;

    vecs[0] = mk("lone_fetch", 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 3, 0, 16'h0010, 0, 16'hA5A5);
    vecs[1] = mk("d_read",     0, 1, 0, 16'h0000, 16'h0022, 16'h0000, 1, 1, 16'h0022, 0, 16'h5A78);
    vecs[2] = mk("d_write",    0, 1, 1, 16'h0000, 16'h0040, 16'h1234, 2, 1, 16'h0040, 1, 16'h0000);
    vecs[3] = mk("collide_d",  1, 1, 1, 16'h0010, 16'h0050, 16'hBEEF, 3, 1, 16'h0050, 1, 16'h0000);
    vecs[4] = mk("fetch_wr40", 1, 0, 0, 16'h0040, 16'h0000, 16'h0000, 1, 0, 16'h0040, 0, 16'h1234);
    vecs[5] = mk("d_rd_beef",  0, 1, 0, 16'h0000, 16'h0050, 16'h0000, 4, 1, 16'h0050, 0, 16'hBEEF);
    foreach (vecs[n]) run_vec(vecs[n]);

    // Collision: D write goes first, fetch issues at the IDLE after d_done.
    tick();
    lat_cfg = 3; i_req = 1; d_req = 1; d_we = 1;
    i_addr = 16'h0010; d_addr = 16'h0060; d_wdata = 16'h1234;
    d_done_at = -1; i_done_at = -1; i_data_at_done = '0;
    en_cyc.delete(); en_own_d.delete();
    for (int k = 0; k < 30 && i_done_at < 0; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        en_cyc.push_back(k);
        en_own_d.push_back(mem_addr == 16'h0060);
        if (en_cyc.size() == 1) begin
          check("coll/first_wr", mem_wr, 1'b1);
          check("coll/first_wdata", mem_wdata, 16'h1234);
        end else begin
          check("coll/second_wr", mem_wr, 1'b0);
        end
      end
      if (d_done === 1'b1) d_done_at = k;
      if (i_done === 1'b1) begin i_done_at = k; i_data_at_done = i_rdata; end
      tick();
      if (d_done_at >= 0) d_req = 1'b0;
    end
    i_req = 1'b0;
    check("coll/grants", en_cyc.size(), 2);
    if (en_cyc.size() == 2) begin
      check("coll/first_cycle", en_cyc[0], 1);
      check("coll/first_owner_d", en_own_d[0], 1'b1);
      check("coll/second_cycle", en_cyc[1], 7);
      check("coll/second_owner_d", en_own_d[1], 1'b0);
    end
    check("coll/d_done_cycle", d_done_at, 5);
    check("coll/i_done_cycle", i_done_at, 11);
    check("coll/i_rdata", i_data_at_done, 16'hA5A5);

    // Starvation with both held: D,D,D,D,I repeating; spacing 3+L.
    tick();
    lat_cfg = 1; i_req = 1; d_req = 1; d_we = 0;
    i_addr = 16'h0100; d_addr = 16'h0200;
    en_cyc.delete(); en_own_d.delete();
    for (int k = 0; k < 200 && en_cyc.size() < 10; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        en_cyc.push_back(k);
        en_own_d.push_back(mem_addr == 16'h0200);
      end
      if (en_cyc.size() < 10) tick();
    end
    tick(); i_req = 0; d_req = 0;
    repeat (6) tick();
    check("starve/grants", en_cyc.size(), 10);
    foreach (en_cyc[n]) begin
      check($sformatf("starve/owner_d[%0d]", n), en_own_d[n], (n % 5) != 4);
      if (n > 0) check($sformatf("starve/spacing[%0d]", n), en_cyc[n] - en_cyc[n-1], 4);
    end

    // Reset during WAIT; the stale mem_valid lands in IDLE afterwards.
    tick();
    lat_cfg = 4; i_req = 1; i_addr = 16'h0010;
    tick();
    @(negedge clk);
    check("rstwait/issue", mem_en, 1'b1);
    tick(); rst = 1'b1; i_req = 1'b0;
    tick(); rst = 1'b0;
    for (int k = 3; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("rstwait/no_done[%0d]", k), i_done || d_done, 1'b0);
      check($sformatf("rstwait/no_en[%0d]", k), mem_en, 1'b0);
      if (k == 3) begin
        check("rstwait/mem_addr", mem_addr, 16'h0);
        check("rstwait/mem_wr", mem_wr, 1'b0);
      end
      tick();
    end
    check("rstwait/i_rdata", i_rdata, 16'h0);
    check("rstwait/d_rdata", d_rdata, 16'h0);
    run_vec(mk("post_rst", 1, 0, 0, 16'h0040, 16'h0000, 16'h0000, 2, 0, 16'h0040, 0, 16'h1234));

    // Spurious mem_valid in IDLE must change nothing.
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("spur/no_done[%0d]", k), i_done || d_done, 1'b0);
      check($sformatf("spur/no_en[%0d]", k), mem_en, 1'b0);
    end
    check("spur/i_rdata", i_rdata, 16'h1234);
    check("spur/d_rdata", d_rdata, 16'h0);
    run_vec(mk("post_spur", 1, 0, 0, 16'h0022, 16'h0000, 16'h0000, 1, 0, 16'h0022, 0, 16'h5A78));

    // Randomized traffic against the transaction-level model.
    do_reset();
    lat_cfg = 0;
    m_cyc = 0; m_next_arb = 0; m_issue = -1; m_done = -1; m_starve = 0;
    m_busy = 0; m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_i_rd = '0; m_d_rd = '0;
    for (int c = 0; c < 1500; c++) begin
      bit win_i;
      tick();
      i_req   = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      i_addr  = 16'($urandom_range(0, 63));
      d_addr  = 16'($urandom_range(0, 63));
      d_wdata = 16'($urandom);
      @(negedge clk);

      check("rnd/mem_en", mem_en, m_cyc == m_issue);
      if (m_cyc == m_issue) begin
        check("rnd/mem_addr", mem_addr, m_addr);
        check("rnd/mem_wr", mem_wr, m_we);
        if (m_we) check("rnd/mem_wdata", mem_wdata, m_wdata);
      end
      check("rnd/i_done", i_done, (m_cyc == m_done) && !m_own_d);
      check("rnd/d_done", d_done, (m_cyc == m_done) && m_own_d);
      if (m_cyc == m_done && m_own_d && !m_we) check("rnd/d_rdata", d_rdata, m_d_rd);
      check("rnd/i_rdata", i_rdata, m_i_rd);
      check("rnd/i_stall", i_stall, i_req && !((m_cyc == m_done) && !m_own_d));
      check("rnd/d_stall", d_stall, d_req && !((m_cyc == m_done) && m_own_d));

      if (m_cyc == m_next_arb) begin
        if (i_req || d_req) begin
          win_i = i_req && (!d_req || m_starve == LIM);
          if (win_i) m_starve = 0;
          else if (i_req && m_starve < LIM) m_starve++;
          m_own_d = !win_i;
          m_addr  = win_i ? i_addr : d_addr;
          m_we    = win_i ? 1'b0 : d_we;
          m_wdata = d_wdata;
          m_issue = m_cyc + 1;
          m_busy  = 1;
          m_next_arb = -1;
        end else begin
          m_next_arb = m_cyc + 1;
        end
      end else if (m_busy && m_cyc >= m_issue && mem_valid) begin
        m_busy = 0;
        m_done = m_cyc + 1;
        m_next_arb = m_cyc + 2;
        if (m_own_d) m_d_rd = mem_rdata;
        else         m_i_rd = mem_rdata;
      end
      m_cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
